// File: rtl/aes_mc_inv_col_seq_pkg.sv
// Shared definitions for the column-serial inverse MixColumns sequencer:
// state/column geometry, FSM encoding and the GF(2^8) doubling helper.
package aes_mc_inv_col_seq_pkg;

    localparam int STATE_W  = 128;
    localparam int COL_W    = 32;
    localparam int NUM_COLS = 4;
    localparam int BYTE_W   = 8;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_RUN  = 2'd1,
        FSM_DONE = 2'd2
    } fsm_t;

    // Multiply a byte by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mc_single_column_inverse.sv
// Single-column AES inverse MixColumns. Byte r of the column sits at
// bits [8r+7:8r]; each output row is a rotated {0e,0b,0d,09} combination.
module aes_mc_single_column_inverse
    import aes_mc_inv_col_seq_pkg::*;
(
    input  logic [COL_W-1:0] cin,
    output logic [COL_W-1:0] cout
);

    logic [BYTE_W-1:0] m9  [NUM_COLS];
    logic [BYTE_W-1:0] m11 [NUM_COLS];
    logic [BYTE_W-1:0] m13 [NUM_COLS];
    logic [BYTE_W-1:0] m14 [NUM_COLS];

    // Per input byte: build x2/x4/x8 by repeated doubling, then the four
    // constant multiples the inverse matrix needs.
    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_mul
            logic [BYTE_W-1:0] a;
            logic [BYTE_W-1:0] x2;
            logic [BYTE_W-1:0] x4;
            logic [BYTE_W-1:0] x8;
            assign a       = cin[gi*BYTE_W +: BYTE_W];
            assign x2      = xtime(a);
            assign x4      = xtime(x2);
            assign x8      = xtime(x4);
            assign m9[gi]  = x8 ^ a;
            assign m11[gi] = x8 ^ x2 ^ a;
            assign m13[gi] = x8 ^ x4 ^ a;
            assign m14[gi] = x8 ^ x4 ^ x2;
        end
    endgenerate

    // Output row r = 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3] (indices mod 4).
    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_row
            assign cout[gi*BYTE_W +: BYTE_W] = m14[gi]
                                             ^ m11[(gi + 1) % NUM_COLS]
                                             ^ m13[(gi + 2) % NUM_COLS]
                                             ^ m9[(gi + 3) % NUM_COLS];
        end
    endgenerate

endmodule

// File: rtl/aes_mc_inv_col_seq.sv
// Inverse MixColumns over a full AES state using one shared column unit,
// one column per cycle. Fixed 4-cycle latency in both normal and bypass mode.
module aes_mc_inv_col_seq
    import aes_mc_inv_col_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_bypass,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data
);

    fsm_t               state_reg;
    fsm_t               state_next;
    logic [STATE_W-1:0] st_reg;
    logic [STATE_W-1:0] res_reg;
    logic [1:0]         col_cnt;
    logic               bypass_reg;
    logic               accept;

    logic [COL_W-1:0]    st_col [NUM_COLS];
    logic [COL_W-1:0]    unit_in;
    logic [COL_W-1:0]    unit_out;
    logic [COL_W-1:0]    wb_col;
    logic [NUM_COLS-1:0] col_we;

    // Column split of the captured state and per-column write enables.
    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
            assign st_col[gi] = st_reg[gi*COL_W +: COL_W];
            assign col_we[gi] = (state_reg == FSM_RUN) && (col_cnt == 2'(gi));
        end
    endgenerate

    // The unit always sees the selected column so bypass costs the same time.
    assign unit_in = st_col[col_cnt];

    aes_mc_single_column_inverse u_unit (
        .cin  (unit_in),
        .cout (unit_out)
    );

    assign wb_col   = bypass_reg ? unit_in : unit_out;
    assign accept   = in_valid & in_ready;
    assign out_data = res_reg;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FSM_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: DONE hands straight over to RUN when a new state is waiting.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FSM_IDLE: if (accept) state_next = FSM_RUN;
            FSM_RUN:  if (col_cnt == 2'd3) state_next = FSM_DONE;
            FSM_DONE: if (out_ready) state_next = accept ? FSM_RUN : FSM_IDLE;
            default:  state_next = FSM_IDLE;
        endcase
    end

    // Handshake outputs decoded from the FSM state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            FSM_IDLE: in_ready = 1'b1;
            FSM_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Input capture and column counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_reg     <= '0;
            bypass_reg <= 1'b0;
            col_cnt    <= 2'd0;
        end else if (accept) begin
            st_reg     <= in_data;
            bypass_reg <= in_bypass;
            col_cnt    <= 2'd0;
        end else if (state_reg == FSM_RUN) begin
            col_cnt    <= col_cnt + 2'd1;
        end
    end

    // Column write-back into the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_reg <= '0;
        end else begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (col_we[c]) res_reg[c*COL_W +: COL_W] <= wb_col;
            end
        end
    end

endmodule

// File: tb/tb_aes_mc_inv_col_seq.sv
// Directed bench for the column-serial inverse MixColumns sequencer:
// known-answer vectors, bypass, backpressure, mid-run reset and streaming.
module tb_aes_mc_inv_col_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int checks   = 0;
    int failures = 0;

    logic [127:0] exp_q[$];

    aes_mc_inv_col_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference GF(2^8) multiply (shift-and-add, reduce by 0x11B).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s, input logic byp);
        logic [127:0] r = '0;
        logic [7:0] m [4];
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        if (byp) return s;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(s[32*c + 8*k +: 8], m[(k - row + 4) % 4]);
                r[32*c + 8*row +: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a state (called at a negedge); returns at the negedge after accept.
    task automatic send(input logic [127:0] d, input logic b);
        int n = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_bypass = b;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("send_timeout", 128'(n >= 200), 128'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = 1'($urandom);
    endtask

    // Count negedges from the post-accept negedge until out_valid rises.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    localparam logic [127:0] SINGLE_IN  = {96'h0, 32'hbca14d8e};
    localparam logic [127:0] SINGLE_OUT = {96'h0, 32'h455313db};
    localparam logic [127:0] FULL_IN    = {32'hd6d7d5d5, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
    localparam logic [127:0] FULL_OUT   = {32'hd5d4d4d4, 32'h01010101, 32'h5c220af2, 32'h455313db};

    initial begin
        int lat;
        logic [127:0] held;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bypass = 1'b0; out_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_data",  out_data,        128'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // Single-column known answer.
        send(SINGLE_IN, 1'b0);
        wait_result(lat);
        $display("txn single: latency=%0d out=%h", lat, out_data);
        chk("single_latency", 128'(lat), 128'd4);
        chk("single_data",    out_data,  SINGLE_OUT);
        @(negedge clk);
        chk("single_idle_valid", 128'(out_valid), 128'd0);
        chk("single_idle_ready", 128'(in_ready),  128'd1);

        // Full-state known answer.
        send(FULL_IN, 1'b0);
        wait_result(lat);
        $display("txn full: latency=%0d out=%h", lat, out_data);
        chk("full_latency", 128'(lat), 128'd4);
        chk("full_data",    out_data,  FULL_OUT);
        @(negedge clk);

        // Bypass: same timing, data passed through.
        send(FULL_IN, 1'b1);
        wait_result(lat);
        $display("txn bypass: latency=%0d out=%h", lat, out_data);
        chk("bypass_latency", 128'(lat), 128'd4);
        chk("bypass_data",    out_data,  FULL_IN);
        @(negedge clk);

        // Backpressure: result must hold in DONE while out_ready is low.
        out_ready = 1'b0;
        send(FULL_IN, 1'b0);
        wait_result(lat);
        chk("bp_latency", 128'(lat), 128'd4);
        held = out_data;
        chk("bp_data", held, FULL_OUT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 128'(out_valid), 128'd1);
            chk("bp_hold_data",  out_data,        held);
            chk("bp_hold_ready", 128'(in_ready),  128'd0);
        end
        $display("txn backpressure: held=%h", held);
        // Release with a new state waiting: handoff in the DONE cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = SINGLE_IN;
        in_bypass = 1'b0;
        #1;
        chk("bp_handoff_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '1;
        chk("bp_after_handoff_valid", 128'(out_valid), 128'd0);
        wait_result(lat);
        $display("txn handoff: latency=%0d out=%h", lat, out_data);
        chk("handoff_latency", 128'(lat), 128'd4);
        chk("handoff_data",    out_data,  SINGLE_OUT);
        @(negedge clk);

        // Reset two edges after accept discards the partial result.
        send(FULL_IN, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_in_ready",  128'(in_ready),  128'd1);
        chk("midrst_out_data",  out_data,        128'd0);
        repeat (6) @(negedge clk);
        chk("midrst_no_ghost", 128'(out_valid), 128'd0);
        send(FULL_IN, 1'b0);
        wait_result(lat);
        $display("txn after_reset: latency=%0d out=%h", lat, out_data);
        chk("midrst_latency", 128'(lat), 128'd4);
        chk("midrst_data",    out_data,  FULL_OUT);
        @(negedge clk);

        // Streaming with random gaps on both sides.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [127:0] s;
                    logic b;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    s = {$urandom, $urandom, $urandom, $urandom};
                    b = (i == 5);
                    exp_q.push_back(ref_model(s, b));
                    send(s, b);
                end
            end
            begin
                int got = 0;
                int n   = 0;
                while (got < 8 && n < 2000) begin
                    @(negedge clk);
                    n++;
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (out_valid && out_ready) begin
                        logic [127:0] e;
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~out_data;
                        $display("txn stream %0d: out=%h exp=%h", got, out_data, e);
                        chk("stream_data", out_data, e);
                        got++;
                    end
                end
                chk("stream_count", 128'(got), 128'd8);
            end
        join
        @(negedge clk);
        chk("stream_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Last-resort bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
